// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   port_id_t     : identifies a requester (PORT_CPU = p0, PORT_LDR = p1)
//   DMEM_ADDR_W   : default byte-address width
//   DMEM_DATA_W   : default data width
//   STAT_W        : width of the per-port grant statistics counters
//   port_onehot() : converts a port id into a one-hot grant vector
// Build option: DMEM_ARB_RR_EN (round-robin conflict resolution) is consumed
// by dmem_arb_rr; nothing here depends on it.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 64;
    localparam int STAT_W      = 32;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_id_t;

    function automatic logic [1:0] port_onehot(input port_id_t p);
        return (p == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports, the shared read-data return and the
// data-memory port of dmem_arbiter.
//   slave  modport : the arbiter (takes requests and mem_rdata, drives grants,
//                    rvalid/rdata, memory strobes and statistics)
//   master modport : the environment (requesters plus the memory itself)
// Statistics: stat_p0_gnt / stat_p1_gnt count completed handshakes per port.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DMEM_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DMEM_DATA_W
);
    // requester side
    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p1_wdata;
    logic              p0_gnt;
    logic              p1_gnt;
    logic              p0_rvalid;
    logic              p1_rvalid;
    logic [DATA_W-1:0] rdata;

    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // statistics
    logic [dmem_arb_pkg::STAT_W-1:0] stat_p0_gnt;
    logic [dmem_arb_pkg::STAT_W-1:0] stat_p1_gnt;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
               mem_addr, mem_wdata, mem_we, mem_re,
               stat_p0_gnt, stat_p1_gnt
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
               mem_addr, mem_wdata, mem_we, mem_re,
               stat_p0_gnt, stat_p1_gnt
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// -----------------------------------------------------------------------------
// dmem_arb_rr
// Purely combinational grant selection for the two-port arbiter.
//   req[1:0]   : live requests (bit 0 = p0/CPU, bit 1 = p1/loader)
//   last_grant : port that completed the most recent handshake
//   gnt[1:0]   : one-hot (or zero) grant
// A lone requester always wins. On a conflict:
//   DMEM_ARB_RR_EN defined   : the port that was NOT granted last wins
//   DMEM_ARB_RR_EN undefined : p0 always wins; last_grant is ignored
// -----------------------------------------------------------------------------
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
`ifdef DMEM_ARB_RR_EN
                gnt = (last_grant == PORT_CPU) ? port_onehot(PORT_LDR)
                                               : port_onehot(PORT_CPU);
`else
                gnt = port_onehot(PORT_CPU);
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

`ifndef DMEM_ARB_RR_EN
    // Fixed priority keeps the last_grant input for a uniform interface.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port data-memory arbiter: p0 (CPU data port) and p1 (loader/debug port)
// share one data memory with a one-cycle read latency.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-low reset
//   bus : dmem_arbiter_if.slave (requesters, read return, memory port, stats)
// Behaviour:
//   - zero-latency combinational grant, at most one port per cycle
//   - memory strobes/address/data mirror the granted port, zero otherwise
//   - writes finish in the grant cycle; reads return one cycle later on the
//     owner's rvalid with rdata = mem_rdata
//   - a one-entry owner register allows a read every cycle
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution
// (see dmem_arb_rr); without it p0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    // state
    port_id_t          last_grant_q, last_grant_d;
    port_id_t          owner_q,      owner_d;
    logic              owner_vld_q,  owner_vld_d;
    logic [STAT_W-1:0] stat_p0_q,    stat_p0_d;
    logic [STAT_W-1:0] stat_p1_q,    stat_p1_d;

    // grant path
    logic [1:0]        req_live;
    logic [1:0]        gnt;
    logic              sel_we;
    logic              mem_re_int;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              resp_live;

    // Masking requests with rst forces every grant and memory strobe low
    // while reset is held, without a separate override path.
    assign req_live = {bus.p1_req & rst, bus.p0_req & rst};

    dmem_arb_rr u_rr (
        .req        (req_live),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[1]) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end else if (gnt[0]) begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
        end
    end

    assign mem_re_int    = (|gnt) & ~sel_we;

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.mem_we    = sel_we;
    assign bus.mem_re    = mem_re_int;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // next state
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        owner_vld_d  = mem_re_int;
        stat_p0_d    = stat_p0_q;
        stat_p1_d    = stat_p1_q;

        // gnt implies req, so any grant is a completed handshake
        if (gnt[1]) begin
            last_grant_d = PORT_LDR;
            stat_p1_d    = stat_p1_q + STAT_W'(1);
        end else if (gnt[0]) begin
            last_grant_d = PORT_CPU;
            stat_p0_d    = stat_p0_q + STAT_W'(1);
        end

        if (mem_re_int) begin
            owner_d = gnt[1] ? PORT_LDR : PORT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // PORT_LDR here lets p0 win the first conflict in round-robin mode
            last_grant_q <= PORT_LDR;
            owner_q      <= PORT_CPU;
            owner_vld_q  <= 1'b0;
            stat_p0_q    <= '0;
            stat_p1_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            owner_vld_q  <= owner_vld_d;
            stat_p0_q    <= stat_p0_d;
            stat_p1_q    <= stat_p1_d;
        end
    end

    // A read response pending when reset is asserted is dropped: rvalid and
    // rdata are qualified by rst as well as the owner flag.
    assign resp_live       = owner_vld_q & rst;
    assign bus.p0_rvalid   = resp_live & (owner_q == PORT_CPU);
    assign bus.p1_rvalid   = resp_live & (owner_q == PORT_LDR);
    assign bus.rdata       = resp_live ? bus.mem_rdata : '0;

    assign bus.stat_p0_gnt = stat_p0_q;
    assign bus.stat_p1_gnt = stat_p1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency memory.
// Read expectations are queued when a read is granted; a separate monitor
// pops and compares them whenever an rvalid appears.
// Conflict expectations follow DMEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic        port;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem_arr [0:31];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural data memory, word index = addr[7:3]
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem_arr[bus.mem_addr[7:3]];
        if (bus.mem_we) mem_arr[bus.mem_addr[7:3]] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr, input logic [63:0] wd);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr, input logic [63:0] wd);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 32'h0, 64'h0);
        set_p1(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic push_rd(input logic port, input logic [63:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // monitor: one line per read response
    initial begin
        forever begin
            @(negedge clk);
            if (bus.p0_rvalid || bus.p1_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {62'h0, bus.p1_rvalid, bus.p0_rvalid}, 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("rsp cycle=%0d p0_rvalid=%0b p1_rvalid=%0b rdata=%0h",
                             cyc, bus.p0_rvalid, bus.p1_rvalid, bus.rdata);
                    chk("rvalid_port", {62'h0, bus.p1_rvalid, bus.p0_rvalid},
                        e.port ? 64'h2 : 64'h1);
                    chk("rdata", bus.rdata, e.data);
                    chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic [3:0]  exp_win;
        logic [63:0] exp_p0_cnt;
        logic [63:0] exp_p1_cnt;
        int          p0_n;
        int          p1_n;
        logic        w;

`ifdef DMEM_ARB_RR_EN
        exp_win    = 4'b1010;   // bit k = winner of conflict k (1 = p1)
        exp_p0_cnt = 64'd2;
        exp_p1_cnt = 64'd2;
`else
        exp_win    = 4'b0000;
        exp_p0_cnt = 64'd4;
        exp_p1_cnt = 64'd0;
`endif

        for (int i = 0; i < 32; i++) mem_arr[i] = 64'h0;
        mem_arr[1] = 64'h1111_0008;   // 0x08
        mem_arr[2] = 64'hDEAD;        // 0x10
        mem_arr[3] = 64'h3333_0018;   // 0x18
        bus.mem_rdata = 64'h0;
        idle();

        // ---- reset: outputs forced low even with requests present
        set_p0(1'b1, 1'b0, 32'h10, 64'h0);
        set_p1(1'b1, 1'b1, 32'h20, 64'h77);
        repeat (2) step();
        @(negedge clk);
        $display("txn reset hold with both requests");
        chk("rst_p0_gnt", bus.p0_gnt, 0);
        chk("rst_p1_gnt", bus.p1_gnt, 0);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);

        // ---- p0 reads 0x10 right after reset
        step();
        rst = 1'b1;
        set_p1(1'b0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        $display("txn p0 read 0x10");
        chk("stat_p0_reset", bus.stat_p0_gnt, 0);
        chk("stat_p1_reset", bus.stat_p1_gnt, 0);
        chk("rd10_p0_gnt", bus.p0_gnt, 1);
        chk("rd10_p1_gnt", bus.p1_gnt, 0);
        chk("rd10_mem_re", bus.mem_re, 1);
        chk("rd10_mem_addr", bus.mem_addr, 64'h10);
        push_rd(1'b0, 64'hDEAD);
        step();
        idle();
        @(negedge clk);
        chk("idle_gnt", {bus.p1_gnt, bus.p0_gnt}, 0);
        chk("idle_mem_re", bus.mem_re, 0);

        // ---- p0 reads 0x08, then p1 reads 0x18 next cycle
        step();
        set_p0(1'b1, 1'b0, 32'h08, 64'h0);
        @(negedge clk);
        $display("txn p0 read 0x08");
        chk("rd08_p0_gnt", bus.p0_gnt, 1);
        push_rd(1'b0, 64'h1111_0008);
        step();
        set_p0(1'b0, 1'b0, 32'h0, 64'h0);
        set_p1(1'b1, 1'b0, 32'h18, 64'h0);
        @(negedge clk);
        $display("txn p1 read 0x18");
        chk("rd18_p1_gnt", bus.p1_gnt, 1);
        chk("rd18_mem_addr", bus.mem_addr, 64'h18);
        push_rd(1'b1, 64'h3333_0018);
        step();
        idle();
        @(negedge clk);

        // ---- reset, then both ports write every cycle for 4 cycles
        step();
        rst = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b1;
        p0_n = 0;
        p1_n = 0;
        for (int k = 0; k < 4; k++) begin
            set_p0(1'b1, 1'b1, 32'h40 + 32'(8 * p0_n), 64'hA0 + 64'(p0_n));
            set_p1(1'b1, 1'b1, 32'h60 + 32'(8 * p1_n), 64'hB0 + 64'(p1_n));
            @(negedge clk);
            w = exp_win[k];
            $display("txn conflict write %0d expected winner p%0d", k, w);
            chk("cf_p0_gnt", bus.p0_gnt, !w);
            chk("cf_p1_gnt", bus.p1_gnt, w);
            chk("cf_mem_we", bus.mem_we, 1);
            chk("cf_mem_re", bus.mem_re, 0);
            chk("cf_mem_addr", bus.mem_addr,
                w ? 64'h60 + 64'(8 * p1_n) : 64'h40 + 64'(8 * p0_n));
            if (w) p1_n++; else p0_n++;
            step();
        end
        idle();
        @(negedge clk);
        chk("stat_p0_cf", bus.stat_p0_gnt, exp_p0_cnt);
        chk("stat_p1_cf", bus.stat_p1_gnt, exp_p1_cnt);

        // ---- p1 writes 0x55 to 0x20, p0 reads it back
        step();
        set_p1(1'b1, 1'b1, 32'h20, 64'h55);
        @(negedge clk);
        $display("txn p1 write 0x20");
        chk("wr20_p1_gnt", bus.p1_gnt, 1);
        chk("wr20_mem_we", bus.mem_we, 1);
        chk("wr20_mem_wdata", bus.mem_wdata, 64'h55);
        step();
        set_p1(1'b0, 1'b0, 32'h0, 64'h0);
        set_p0(1'b1, 1'b0, 32'h20, 64'h0);
        @(negedge clk);
        $display("txn p0 read 0x20");
        chk("rd20_p0_gnt", bus.p0_gnt, 1);
        push_rd(1'b0, 64'h55);
        step();
        idle();
        @(negedge clk);

        // ---- read granted, then reset: response must be dropped
        step();
        set_p0(1'b1, 1'b0, 32'h10, 64'h0);
        @(negedge clk);
        $display("txn p0 read 0x10 followed by reset");
        chk("drop_p0_gnt", bus.p0_gnt, 1);
        step();
        rst = 1'b0;
        set_p0(1'b0, 1'b0, 32'h0, 64'h0);
        set_p1(1'b1, 1'b0, 32'h08, 64'h0);
        @(negedge clk);
        chk("drop_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
        chk("drop_rdata", bus.rdata, 0);
        chk("drop_p1_gnt", bus.p1_gnt, 0);
        chk("drop_mem_re", bus.mem_re, 0);
        step();
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("drop_after_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
        chk("stat_p0_rst2", bus.stat_p0_gnt, 0);
        chk("stat_p1_rst2", bus.stat_p1_gnt, 0);

        repeat (3) step();
        chk("pending_reads", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of both requesters and the memory port.
REQ-002 Parameter: DATA_W, 64, data width of read and write data.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-005 Port: p0_req / p1_req  input  1 each  access request; p0 is the CPU data port, p1 is the loader/debug port.
REQ-006 Port: p0_we / p1_we  input  1 each  write when 1, read when 0; valid while req=1.
REQ-007 Port: p0_addr / p1_addr  input  ADDR_W each  access address.
REQ-008 Port: p0_wdata / p1_wdata  input  DATA_W each  write data.
REQ-009 Port: p0_gnt / p1_gnt  output  1 each  access accepted this cycle.
REQ-010 Port: p0_rvalid / p1_rvalid  output  1 each  read data valid this cycle.
REQ-011 Port: rdata  output  DATA_W  read data shared by both ports; qualified by pX_rvalid.
REQ-012 Port: mem_addr / mem_wdata  output  ADDR_W / DATA_W  address and write data to data memory.
REQ-013 Port: mem_we / mem_re  output  1 each  memory write and read strobes.
REQ-014 Port: mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_re.

Function
REQ-015 The arbiter SHALL grant at most one port per cycle; gnt is combinational from req and arbitration state, with zero-cycle grant latency.
REQ-016 mem_addr, mem_wdata and mem_we/mem_re SHALL mirror the granted port; with no grant, mem_we=0, mem_re=0 and mem_addr/mem_wdata=0.
REQ-017 A requester SHALL hold req, we, addr and wdata stable until it sees gnt=1; the handshake completes on a cycle where req=1 and gnt=1.
REQ-018 A write SHALL complete in the grant cycle; no rvalid is issued for a write.
REQ-019 A granted read SHALL produce pX_rvalid=1 for exactly one cycle, one cycle after the grant, with rdata=mem_rdata; a one-entry owner register records the read's port.
REQ-020 Back-to-back reads, including reads from alternating ports, SHALL be accepted every cycle at full throughput; the owner register updates each cycle.
REQ-021 When only one port requests, that port SHALL be granted immediately regardless of arbitration state.
REQ-022 On simultaneous requests, the winner is decided by the REQ-031 policy.
REQ-023 The 1-bit last_grant state SHALL update only on a completed handshake.
REQ-024 With no request, rvalid behaviour SHALL still follow the owner register; a read granted in cycle N returns in N+1 even if both req lines drop.

Reset
REQ-025 While rst=0 at a clock edge, last_grant SHALL be set to 1 so that p0 wins the first conflict.
REQ-026 While rst=0 at a clock edge, the owner valid flag and both rvalid outputs SHALL clear to 0.
REQ-027 During reset, gnt outputs and mem_we/mem_re SHALL be forced to 0, and rdata SHALL read 0.
REQ-028 A read granted in the cycle before reset asserts SHALL NOT produce rvalid; the response is dropped.
REQ-029 Statistics counters SHALL clear to 0 on reset.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN selects the arbitration policy.
REQ-031 With DMEM_ARB_RR_EN defined, conflicts SHALL be resolved round-robin: the port not equal to last_grant wins.
REQ-032 Without DMEM_ARB_RR_EN, conflicts SHALL be resolved by fixed priority with p0 always winning, and last_grant SHALL be present but unused.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the port_id_t typedef (1-bit: PORT_CPU=0, PORT_LDR=1) and the default ADDR_W/DATA_W constants.
REQ-034 Grant selection SHALL be isolated in sub-module dmem_arb_rr, combinational from req[1:0] and last_grant to gnt[1:0]; dmem_arbiter holds all registers.

Verification
REQ-035 Reset then p0 reads addr 0x10, where memory holds 0xDEAD -> p0_gnt=1 in cycle 0; p0_rvalid=1 with rdata=0xDEAD in cycle 1; p1_rvalid=0.
REQ-036 p0 and p1 both write every cycle for 4 cycles with RR enabled -> grants go p0,p1,p0,p1; mem_we=1 each cycle; no rvalid.
REQ-037 Same stimulus as REQ-036 without DMEM_ARB_RR_EN -> p0 is granted all 4 cycles; p1 holds req stable with gnt=0 throughout.
REQ-038 p0 reads 0x8 in cycle N and p1 reads 0x18 in cycle N+1 -> p0_rvalid in N+1 and p1_rvalid in N+2, each with correct data.
REQ-039 A read is granted in cycle N and rst=0 at edge N+1 -> no rvalid in N+1; all outputs are 0 during reset.
REQ-040 p1 writes 0x55 to 0x20, then p0 reads 0x20 -> p0 rdata=0x55.
